booth_operand_sequencer: RTL
============================

Name: booth_operand_sequencer

Overview:
- Upstream feeder for the 16-bit Booth multiplier (datapath plus controller pair).
- Accepts signed operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Serialises each pair onto the multiplier's shared data_in bus with the required start/load timing, waits for done, captures the 2*WIDTH product, and presents it downstream over a second valid/ready interface.
- Includes a watchdog that detects a hung multiplier.

Parameters:
- WIDTH, 16: operand width; product is 2*WIDTH.
- DEPTH, 4: operand FIFO entries; power of two, at least 2.
- TIMEOUT, 64: maximum cycles from start to mul_done before abort.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept a pair
- in_mcand  in  WIDTH  multiplicand (signed)
- in_mplier  in  WIDTH  multiplier (signed)
- mul_start  out  1  start pulse to multiplier controller
- mul_data  out  WIDTH  shared load bus to multiplier (data_in)
- mul_done  in  1  multiplier completion
- mul_prod  in  2*WIDTH  multiplier result {A,Q}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_prod  out  2*WIDTH  captured product
- out_timeout  out  1  qualifies out_prod: 1 = aborted on timeout, out_prod = 0
- busy  out  1  FSM not in IDLE
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset values: in_ready=0 during the rst cycle, then 1. mul_start=0, mul_data=0, out_valid=0, out_prod=0, out_timeout=0, busy=0, fifo_count=0. FIFO pointers and watchdog cleared.
- FIFO:
  - Write when in_valid && in_ready; in_ready = (count < DEPTH).
  - Read (pop) only on the IDLE->START transition.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push while full is ignored (in_ready is already 0).
- FSM states: IDLE, START, LOAD_M, LOAD_Q, WAIT, HOLD.
  - IDLE: if count>0 and no result is pending (out_valid=0), pop the head into the operand registers and go to START.
  - START: mul_start=1 for exactly this cycle; mul_data=0; go to LOAD_M.
  - LOAD_M: mul_data=multiplicand; go to LOAD_Q.
  - LOAD_Q: mul_data=multiplier; clear the watchdog; go to WAIT.
  - WAIT: mul_data=0.
    - mul_done=1: capture mul_prod into out_prod, out_timeout=0, out_valid=1 next cycle, go to HOLD.
    - Else, watchdog reaches TIMEOUT-1: out_prod=0, out_timeout=1, out_valid=1, go to HOLD.
    - If mul_done arrives in the same cycle the watchdog expires, done wins.
  - HOLD: out_valid held with out_prod and out_timeout stable until out_ready=1, then go to IDLE.
    - If out_valid && out_ready and the FIFO is non-empty, the next pair may pop on the cycle after the handshake, so IDLE lasts a minimum of 1 cycle.
- Latency: pop to mul_start is 1 cycle. First accepted pair into an empty idle block gives mul_start 2 cycles after the in_valid handshake.
- mul_done asserted outside WAIT is ignored.
- Products are passed through unmodified; sign handling belongs to the multiplier. mul_prod is sampled only in the done cycle.
- busy = (state != IDLE).
- rst asserted mid-operation:
  - Returns to IDLE in the next cycle and discards the FIFO contents and any pending result.
  - mul_start is never emitted during or on the cycle after rst.

Test Plan:
- Single pair: mcand=14, mplier=10; model returns done after 17 cycles with mul_prod=140 -> mul_start pulse 1 cycle, mul_data 14 then 10 on consecutive cycles, out_prod=140, out_timeout=0.
- Signed: mcand=-3 (16'hFFFD), mplier=7 -> out_prod=32'hFFFFFFEB held stable while out_ready=0 for 5 cycles, released on the first out_ready=1.
- Back-to-back: push 5 pairs with DEPTH=4 while the first is running -> in_ready drops at count=4, all 5 results emerge in order, fifo_count returns to 0.
- Timeout: model never asserts done -> out_valid with out_timeout=1 and out_prod=0 exactly TIMEOUT cycles after LOAD_Q; next pair proceeds normally.
- Race: mul_done coincides with the watchdog expiry -> out_timeout=0, product captured.
- Reset in WAIT with 2 queued pairs -> next cycle busy=0, fifo_count=0, out_valid=0, no mul_start; a late mul_done is ignored.

Source files
------------

// File: rtl/booth_operand_sequencer.sv
// Operand feeder for the Booth multiplier: buffers signed pairs, drives the start/load
// sequence on the shared data bus, and returns the product or a watchdog abort downstream.
module booth_operand_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_mcand,
    input  logic [WIDTH-1:0]       in_mplier,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_data,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_prod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_prod,
    output logic                   out_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    // state  | meaning
    // IDLE   | waiting for a queued pair and no pending result
    // START  | mul_start pulse, bus idle
    // LOAD_M | multiplicand on the bus
    // LOAD_Q | multiplier on the bus, watchdog armed
    // WAIT   | waiting for mul_done or watchdog expiry
    // HOLD   | result presented until out_ready
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD_M,
        ST_LOAD_Q,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [2*WIDTH-1:0]     fifo_mem_q [DEPTH];
    logic [2*WIDTH-1:0]     fifo_mem_d [DEPTH];
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic                   mul_start_q, mul_start_d;
    logic [WIDTH-1:0]       mul_data_q, mul_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]     out_prod_q, out_prod_d;
    logic                   out_timeout_q, out_timeout_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   push;
    logic                   pop;

    assign in_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_IDLE) && (count_q != '0) && !out_valid_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        fifo_mem_d    = fifo_mem_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        mul_start_d   = 1'b0;
        mul_data_d    = mul_data_q;
        out_valid_d   = out_valid_q;
        out_prod_d    = out_prod_q;
        out_timeout_d = out_timeout_q;
        wd_d          = wd_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = {in_mcand, in_mplier};
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            {mcand_d, mplier_d} = fifo_mem_q[rd_ptr_q];
            rd_ptr_d            = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Outputs are registered, so each branch sets what the next state presents.
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d     = ST_START;
                    mul_start_d = 1'b1;
                    mul_data_d  = '0;
                end
            end
            ST_START: begin
                state_d    = ST_LOAD_M;
                mul_data_d = mcand_q;
            end
            ST_LOAD_M: begin
                state_d    = ST_LOAD_Q;
                mul_data_d = mplier_q;
            end
            ST_LOAD_Q: begin
                state_d    = ST_WAIT;
                mul_data_d = '0;
                wd_d       = WD_W'(TIMEOUT - 1);
            end
            ST_WAIT: begin
                if (mul_done) begin
                    state_d       = ST_HOLD;
                    out_prod_d    = mul_prod;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                end else if (wd_q == '0) begin
                    state_d       = ST_HOLD;
                    out_prod_d    = '0;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fifo_mem_q    <= '{default: '0};
            mcand_q       <= '0;
            mplier_q      <= '0;
            mul_start_q   <= 1'b0;
            mul_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_prod_q    <= '0;
            out_timeout_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_mem_q    <= fifo_mem_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            mul_start_q   <= mul_start_d;
            mul_data_q    <= mul_data_d;
            out_valid_q   <= out_valid_d;
            out_prod_q    <= out_prod_d;
            out_timeout_q <= out_timeout_d;
            wd_q          <= wd_d;
        end
    end

    // A start pulse must never reach the multiplier while reset is asserted.
    assign mul_start   = mul_start_q && !rst;
    assign mul_data    = mul_data_q;
    assign out_valid   = out_valid_q;
    assign out_prod    = out_prod_q;
    assign out_timeout = out_timeout_q;
    assign busy        = (state_q != ST_IDLE);
    assign fifo_count  = count_q;

endmodule
